des_byte_io: RTL and testbench
==============================

# des_byte_io

Parametrised byte-serial front end for the DES core. It assembles 64-bit key and text blocks from narrow input beats and launches the core with single-cycle valid pulses. It then waits for the core result and serialises the 64-bit result back out over a narrow port with ready/valid backpressure. It sits between the board-level pins and `des_con`, replacing the zero-extension of single 8-bit inputs with full 64-bit block transfer.

## Interface
- `IO_W`, 8: beat width in bits; must divide 64 (legal: 1, 2, 4, 8, 16, 32, 64).
- `BEATS`, 64/IO_W: beats per block; derived, not overridable.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_in` in IO_W: key beat, MSB-first.
- `key_valid` in 1: key beat strobe.
- `key_ready` out 1: key beat accepted when `key_valid & key_ready`.
- `text_in` in IO_W: text beat, MSB-first.
- `text_valid` in 1: text beat strobe.
- `text_ready` out 1: text beat accepted when `text_valid & text_ready & ~key_valid`.
- `decrypt` in 1: mode. Sampled on the final text beat.
- `key_loaded` out 1: a complete key has been delivered to the core.
- `busy` out 1: state is not IDLE.
- `core_key` out 64, `core_key_valid` out 1: key to the core, with a 1-cycle valid pulse.
- `core_text` out 64, `core_text_valid` out 1, `core_decrypt` out 1: block to the core, with a 1-cycle valid pulse.
- `core_result` in 64, `core_result_valid` in 1: core output.
- `result` out IO_W, `result_valid` out 1, `result_ready` in 1: serialised result, MSB beat first.

## Operation
- States:
  - IDLE: collect beats. Enter LAUNCH after the final text beat.
  - LAUNCH: exactly 1 cycle. Go to WAIT.
  - WAIT: hold until `core_result_valid`. Go to DRAIN.
  - DRAIN: output beats. Return to IDLE after the last beat is accepted.
- `key_ready` = IDLE & text beat count == 0. `text_ready` = IDLE & key_loaded & key beat count == 0.
- Each accepted key beat does `key_sr <= {key_sr, key_in}`. The first key beat clears key_loaded.
- On the BEATS-th key beat:
  - the count wraps to 0;
  - core_key updates;
  - core_key_valid pulses the next cycle;
  - key_loaded is set the same cycle as the pulse.
- Text beats are assembled the same way. On the BEATS-th text beat, the count wraps to 0, and core_text and core_decrypt are latched and held stable until the next launch.
- `core_text_valid` = 1 only in LAUNCH.
- In WAIT, `core_result` is captured into the output shift register in the cycle `core_result_valid` = 1.
- In DRAIN:
  - `result` = out_sr[63 -: IO_W];
  - `result_valid` = 1;
  - on `result_valid & result_ready`, shift left by IO_W and increment the beat count.
- Boundary conditions:
  - `key_valid` and `text_valid` in the same cycle: the key beat wins and the text beat is dropped (text_ready is qualified by ~key_valid).
  - Beats arriving while not ready are dropped without effect.
  - `core_result_valid` outside WAIT is ignored.
  - `result_ready` held low stalls DRAIN indefinitely; result stays stable.
  - WAIT has no timeout.
  - Key reload is possible only between blocks (IDLE, no partial text). A new key does not affect a block already in flight.
- Reset at any point clears the state to IDLE, both counts, the shift registers, key_loaded and all valid outputs. An in-flight core result is discarded.

## Timing
- Reset values: all outputs 0, except `key_ready` = 1 (IDLE, count 0). `text_ready` = 0.
- The final text beat is accepted at edge N. LAUNCH is active in cycle N+1 with `core_text_valid` = 1. WAIT starts at N+2.
- `core_result_valid` is seen in cycle M. The first `result_valid` = 1 is in cycle M+1.
- Drain takes BEATS cycles at full throughput.
- IDLE is reached the cycle after the last beat handshake. `text_ready` can rise that same cycle.
- `core_key_valid` pulses the cycle after the final key beat.
- Minimum block turnaround: 2·BEATS + 2 cycles + core latency.

## Structure
- Package `des_io_pkg` holds:
  - `BLOCK_W` = 64;
  - the state enum (IDLE, LAUNCH, WAIT, DRAIN);
  - a function computing the counter width $clog2(BEATS) (min 1).
- Sub-module `des_beat_shifter`, parametrised by IO_W:
  - shift register plus beat counter;
  - last-beat flag.
  - It is instantiated for key and for text.
  - The output serialiser is inline.

## Test plan
- IO_W=8:
  - Load key 133457799BBCDFF1 (8 beats). key_loaded=1 and one core_key_valid pulse.
  - Load text 0123456789ABCDEF with decrypt=0.
  - Result beats 85,E8,13,54,0F,0A,B4,05.
- Same key, text 85E813540F0AB405, decrypt=1 -> beats 01,23,45,67,89,AB,CD,EF.
- Text beats with key_loaded=0 -> dropped, no core_text_valid. Simultaneous key/text beats -> only the key count advances.
- `result_ready` toggled 1,0,0,1,... during DRAIN -> beat order intact, result stable while stalled, IDLE after beat 8.
- `rst` asserted in WAIT, then core_result_valid arrives -> ignored, all outputs 0, key_loaded=0.
- IO_W=16 and IO_W=64, first vector -> 4 beats 85E8,1354,0F0A,B405, and a single beat respectively.

Source files
------------

// File: rtl/des_io_pkg.sv
// Shared definitions for the DES byte-serial front end.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package des_io_pkg;

  localparam int BLOCK_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DRAIN  = 2'd3
  } io_state_t;

  // Beat counter width; a single-beat block still gets a 1-bit counter.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/des_beat_shifter.sv
// Assembles a 64-bit block from IO_W-bit beats, MSB beat first.
// Latency: 'block' is combinational and complete in the cycle 'last' is high.
// Backpressure: none here; the parent qualifies 'take' with its own ready.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   beat, take - beat data and accept strobe (already qualified by ready)
//   first      - beat counter is at zero (no partial block held)
//   last       - this accepted beat completes the block
//   block      - held beats concatenated with the current beat
module des_beat_shifter
  import des_io_pkg::*;
#(
  parameter int  IO_W  = 8,
  localparam int BEATS = BLOCK_W / IO_W,
  localparam int CNT_W = cnt_width(BEATS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IO_W-1:0]    beat,
  input  logic               take,
  output logic               first,
  output logic               last,
  output logic [BLOCK_W-1:0] block
);

  logic [CNT_W-1:0] cnt;

  assign first = (cnt == '0);
  assign last  = take && (cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (take) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

  // Only the low BLOCK_W-IO_W bits of the history ever reach a full block;
  // anything older has already been shifted out, so it is not stored.
  if (IO_W == BLOCK_W) begin : g_single
    assign block = beat;
  end else begin : g_multi
    logic [BLOCK_W-IO_W-1:0] sr;

    always_ff @(posedge clk) begin
      if (rst) begin
        sr <= '0;
      end else if (take) begin
        sr <= block[BLOCK_W-IO_W-1:0];
      end
    end

    assign block = {sr, beat};
  end

endmodule

// File: rtl/des_byte_io.sv
// Narrow-beat front end for the DES core: loads key/text blocks, launches the
// core, and serialises the 64-bit result back out MSB beat first.
// Latency: launch 1 cycle after the final text beat; first result beat 1 cycle
// after core_result_valid; BEATS cycles to drain at full rate.
// Backpressure: input beats are dropped unless ready; result_ready low stalls
// the drain indefinitely with result held stable.
//
// Ports:
//   clk, rst                           - clock, synchronous active-high reset
//   key_in/key_valid/key_ready         - key beats (accepted on valid & ready)
//   text_in/text_valid/text_ready      - text beats (key beat wins a tie)
//   decrypt                            - mode, sampled with the final text beat
//   key_loaded, busy                   - status
//   core_key/core_key_valid            - key to the core, 1-cycle pulse
//   core_text/core_text_valid/core_decrypt - block to the core, 1-cycle pulse
//   core_result/core_result_valid      - core output, taken only in WAIT
//   result/result_valid/result_ready   - serialised result beats
module des_byte_io
  import des_io_pkg::*;
#(
  parameter int  IO_W  = 8,
  localparam int BEATS = BLOCK_W / IO_W,
  localparam int CNT_W = cnt_width(BEATS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IO_W-1:0]    key_in,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [IO_W-1:0]    text_in,
  input  logic               text_valid,
  output logic               text_ready,
  input  logic               decrypt,
  output logic               key_loaded,
  output logic               busy,
  output logic [BLOCK_W-1:0] core_key,
  output logic               core_key_valid,
  output logic [BLOCK_W-1:0] core_text,
  output logic               core_text_valid,
  output logic               core_decrypt,
  input  logic [BLOCK_W-1:0] core_result,
  input  logic               core_result_valid,
  output logic [IO_W-1:0]    result,
  output logic               result_valid,
  input  logic               result_ready
);

  io_state_t state, state_nxt;

  logic               key_take, key_first, key_last;
  logic               text_take, text_first, text_last;
  logic [BLOCK_W-1:0] key_block, text_block;
  logic [BLOCK_W-1:0] out_sr;
  logic [CNT_W-1:0]   out_cnt;
  logic               out_take, out_last;
  logic               idle;

  assign idle = (state == ST_IDLE);

  // Key reload only between blocks: no partial text may be pending. Text needs
  // a loaded key and no partial key, so a key reload cannot be interleaved.
  assign key_ready  = idle && text_first;
  assign text_ready = idle && key_loaded && key_first;
  assign key_take   = key_valid && key_ready;
  assign text_take  = text_valid && text_ready && !key_valid;

  des_beat_shifter #(.IO_W(IO_W)) u_key_shifter (
    .clk   (clk),
    .rst   (rst),
    .beat  (key_in),
    .take  (key_take),
    .first (key_first),
    .last  (key_last),
    .block (key_block)
  );

  des_beat_shifter #(.IO_W(IO_W)) u_text_shifter (
    .clk   (clk),
    .rst   (rst),
    .beat  (text_in),
    .take  (text_take),
    .first (text_first),
    .last  (text_last),
    .block (text_block)
  );

  // Core-facing registers. A key or block is captured only on its final
  // beat, so the core sees stable values while the next one is assembled.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_loaded     <= 1'b0;
      core_key       <= '0;
      core_key_valid <= 1'b0;
      core_text      <= '0;
      core_decrypt   <= 1'b0;
    end else begin
      core_key_valid <= key_last;
      // Final beat takes priority so a single-beat key ends up loaded.
      if (key_last) begin
        core_key   <= key_block;
        key_loaded <= 1'b1;
      end else if (key_take && key_first) begin
        key_loaded <= 1'b0;
      end
      if (text_last) begin
        core_text    <= text_block;
        core_decrypt <= decrypt;
      end
    end
  end

  // Output serialiser. In DRAIN result_valid is always high, so the handshake
  // reduces to result_ready; using it directly keeps the FSM free of loops.
  assign out_take = (state == ST_DRAIN) && result_ready;
  assign out_last = (out_cnt == CNT_W'(BEATS - 1));
  assign result   = out_sr[BLOCK_W-1 -: IO_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sr  <= '0;
      out_cnt <= '0;
    end else if (state == ST_WAIT && core_result_valid) begin
      out_sr  <= core_result;
      out_cnt <= '0;
    end else if (out_take) begin
      out_sr  <= out_sr << IO_W;
      out_cnt <= out_last ? '0 : out_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    busy            = 1'b1;
    core_text_valid = 1'b0;
    result_valid    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (text_last) state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        core_text_valid = 1'b1;
        state_nxt       = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_result_valid) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        result_valid = 1'b1;
        if (out_take && out_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_des_byte_io.sv
// Bench for des_byte_io at IO_W = 8, 16 and 64. The bench plays the DES core:
// it answers with known-answer results for the reference vectors and with
// random values otherwise, and checks the beat stream against the block value.
module tb_des_byte_io;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] key_dat, text_dat, core_res;
  logic        decrypt;
  logic        key_valid [3];
  logic        text_valid [3];
  logic        core_res_valid [3];
  logic        result_ready [3];

  logic        kr [3], tr [3], kl [3], bz [3], ckv [3], ctv [3], cd [3], rv [3];
  logic [63:0] ck [3], ct [3];
  logic [7:0]  r8;
  logic [15:0] r16;
  logic [63:0] r64;

  int iow [3] = '{8, 16, 64};
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_key [3];

  des_byte_io #(.IO_W(8)) dut8 (
    .clk(clk), .rst(rst),
    .key_in(key_dat[7:0]), .key_valid(key_valid[0]), .key_ready(kr[0]),
    .text_in(text_dat[7:0]), .text_valid(text_valid[0]), .text_ready(tr[0]),
    .decrypt(decrypt), .key_loaded(kl[0]), .busy(bz[0]),
    .core_key(ck[0]), .core_key_valid(ckv[0]),
    .core_text(ct[0]), .core_text_valid(ctv[0]), .core_decrypt(cd[0]),
    .core_result(core_res), .core_result_valid(core_res_valid[0]),
    .result(r8), .result_valid(rv[0]), .result_ready(result_ready[0])
  );

  des_byte_io #(.IO_W(16)) dut16 (
    .clk(clk), .rst(rst),
    .key_in(key_dat[15:0]), .key_valid(key_valid[1]), .key_ready(kr[1]),
    .text_in(text_dat[15:0]), .text_valid(text_valid[1]), .text_ready(tr[1]),
    .decrypt(decrypt), .key_loaded(kl[1]), .busy(bz[1]),
    .core_key(ck[1]), .core_key_valid(ckv[1]),
    .core_text(ct[1]), .core_text_valid(ctv[1]), .core_decrypt(cd[1]),
    .core_result(core_res), .core_result_valid(core_res_valid[1]),
    .result(r16), .result_valid(rv[1]), .result_ready(result_ready[1])
  );

  des_byte_io #(.IO_W(64)) dut64 (
    .clk(clk), .rst(rst),
    .key_in(key_dat), .key_valid(key_valid[2]), .key_ready(kr[2]),
    .text_in(text_dat), .text_valid(text_valid[2]), .text_ready(tr[2]),
    .decrypt(decrypt), .key_loaded(kl[2]), .busy(bz[2]),
    .core_key(ck[2]), .core_key_valid(ckv[2]),
    .core_text(ct[2]), .core_text_valid(ctv[2]), .core_decrypt(cd[2]),
    .core_result(core_res), .core_result_valid(core_res_valid[2]),
    .result(r64), .result_valid(rv[2]), .result_ready(result_ready[2])
  );

  function automatic logic [63:0] res_of(input int d);
    case (d)
      0:       return {56'd0, r8};
      1:       return {48'd0, r16};
      default: return r64;
    endcase
  endfunction

  // Beat i of a block, MSB beat first.
  function automatic logic [63:0] beat_of(input logic [63:0] v, input int w, input int i);
    logic [63:0] s;
    s = v >> (64 - w * (i + 1));
    return (w == 64) ? s : (s & ((64'd1 << w) - 64'd1));
  endfunction

  // Known-answer DES pairs under KEY; anything else yields a marker value.
  function automatic logic [63:0] des_kat(input logic [63:0] k, input logic [63:0] t,
                                          input logic dec);
    if (k == KEY && !dec && t == PT) return CT;
    if (k == KEY && dec && t == CT) return PT;
    return 64'hBAD0BAD0BAD0BAD0;
  endfunction

  task automatic chk(input int d, input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL dut%0d %s observed=%h expected=%h", d, tag, obs, exp);
    end
  endtask

  task automatic send_key(input int d, input logic [63:0] k, input int dual);
    int w;
    int nb;
    w  = iow[d];
    nb = 64 / w;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      if (i == 1) chk(d, "key_loaded_cleared", kl[d], 0);
      chk(d, "key_ready", kr[d], 1);
      key_dat       = k >> (64 - w * (i + 1));
      key_valid[d]  = 1'b1;
      text_valid[d] = (i < dual);
      text_dat      = {$urandom, $urandom};
    end
    @(negedge clk);
    key_valid[d]  = 1'b0;
    text_valid[d] = 1'b0;
    chk(d, "core_key_valid_pulse", ckv[d], 1);
    chk(d, "core_key", ck[d], k);
    chk(d, "key_loaded_set", kl[d], 1);
    exp_key[d] = k;
    @(negedge clk);
    chk(d, "core_key_valid_single", ckv[d], 0);
  endtask

  task automatic send_text(input int d, input logic [63:0] t, input logic dec);
    int w;
    int nb;
    w  = iow[d];
    nb = 64 / w;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      chk(d, "text_ready", tr[d], 1);
      chk(d, "no_early_launch", ctv[d], 0);
      text_dat      = t >> (64 - w * (i + 1));
      text_valid[d] = 1'b1;
      decrypt       = (i == nb - 1) ? dec : ~dec;
    end
    @(negedge clk);
    text_valid[d] = 1'b0;
    decrypt       = ~dec;
    chk(d, "launch_valid", ctv[d], 1);
    chk(d, "core_text", ct[d], t);
    chk(d, "core_decrypt", cd[d], dec);
    chk(d, "busy_launch", bz[d], 1);
    chk(d, "key_ready_busy", kr[d], 0);
  endtask

  // Core latency 'lat' cycles in WAIT, with key beats offered meanwhile.
  task automatic respond(input int d, input logic [63:0] v, input int lat, input bit kat);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk(d, "wait_no_launch", ctv[d], 0);
      chk(d, "wait_busy", bz[d], 1);
      chk(d, "wait_no_result", rv[d], 0);
      chk(d, "wait_key_ready", kr[d], 0);
      key_valid[d] = 1'b1;
      key_dat      = {$urandom, $urandom};
    end
    @(negedge clk);
    key_valid[d] = 1'b0;
    chk(d, "key_held_in_flight", ck[d], exp_key[d]);
    chk(d, "wait_no_launch", ctv[d], 0);
    core_res          = kat ? des_kat(ck[d], ct[d], cd[d]) : v;
    core_res_valid[d] = 1'b1;
  endtask

  // mode 0: always ready; 1: ready 1,0,0 repeating plus a stray core result;
  // 2: random ready.
  task automatic drain(input int d, input logic [63:0] v, input int mode);
    int   w;
    int   nb;
    int   idx;
    int   cyc;
    logic rdy;
    w   = iow[d];
    nb  = 64 / w;
    idx = 0;
    cyc = 0;
    while (idx < nb && cyc < 64) begin
      @(negedge clk);
      core_res_valid[d] = (mode == 1 && cyc == 1);
      if (mode == 1 && cyc == 1) core_res = ~v;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      result_ready[d] = rdy;
      chk(d, "result_valid", rv[d], 1);
      chk(d, "result_beat", res_of(d), beat_of(v, w, idx));
      if (rdy) idx++;
      cyc++;
    end
    chk(d, "drain_beats", idx, nb);
    @(negedge clk);
    result_ready[d]   = 1'b0;
    core_res_valid[d] = 1'b0;
    chk(d, "idle_after_drain", bz[d], 0);
    chk(d, "result_valid_low", rv[d], 0);
    chk(d, "text_ready_after_drain", tr[d], 1);
    if (mode == 0) chk(d, "drain_cycles", cyc, nb);
  endtask

  task automatic run_block(input int d, input logic [63:0] t, input logic dec,
                           input logic [63:0] v, input int lat, input int mode,
                           input bit kat);
    send_text(d, t, dec);
    respond(d, v, lat, kat);
    drain(d, v, mode);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    key_dat  = '0;
    text_dat = '0;
    core_res = '0;
    decrypt  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      key_valid[d]      = 1'b0;
      text_valid[d]     = 1'b0;
      core_res_valid[d] = 1'b0;
      result_ready[d]   = 1'b0;
      exp_key[d]        = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk(d, "rst_key_ready", kr[d], 1);
      chk(d, "rst_text_ready", tr[d], 0);
      chk(d, "rst_key_loaded", kl[d], 0);
      chk(d, "rst_busy", bz[d], 0);
      chk(d, "rst_core_key_valid", ckv[d], 0);
      chk(d, "rst_core_text_valid", ctv[d], 0);
      chk(d, "rst_result_valid", rv[d], 0);
      chk(d, "rst_result", res_of(d), 0);
    end

    // Text beats without a key are dropped.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk(0, "text_ready_no_key", tr[0], 0);
      chk(0, "no_launch_no_key", ctv[0], 0);
      text_dat      = {$urandom, $urandom};
      text_valid[0] = 1'b1;
    end
    @(negedge clk);
    text_valid[0] = 1'b0;
    chk(0, "no_launch_no_key", ctv[0], 0);
    chk(0, "idle_no_key", bz[0], 0);

    // Key load with text beats offered alongside the first three key beats.
    send_key(0, KEY, 3);
    run_block(0, PT, 1'b0, CT, 3, 0, 1'b1);
    run_block(0, CT, 1'b1, PT, 2, 1, 1'b1);

    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) send_key(0, {$urandom, $urandom}, 0);
      run_block(0, {$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                $urandom_range(0, 4), 2, 1'b0);
    end

    for (int d = 1; d < 3; d++) begin
      send_key(d, KEY, 0);
      run_block(d, PT, 1'b0, CT, 1, 0, 1'b1);
      run_block(d, {$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                $urandom_range(0, 4), 2, 1'b0);
    end

    // Reset while waiting on the core; the late result must be ignored.
    send_text(0, PT, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst               = 1'b0;
    core_res          = CT;
    core_res_valid[0] = 1'b1;
    @(negedge clk);
    core_res_valid[0] = 1'b0;
    chk(0, "rst_wait_key_ready", kr[0], 1);
    chk(0, "rst_wait_text_ready", tr[0], 0);
    chk(0, "rst_wait_key_loaded", kl[0], 0);
    chk(0, "rst_wait_busy", bz[0], 0);
    chk(0, "rst_wait_core_key", ck[0], 0);
    chk(0, "rst_wait_core_text", ct[0], 0);
    chk(0, "rst_wait_core_decrypt", cd[0], 0);
    chk(0, "rst_wait_result_valid", rv[0], 0);
    chk(0, "rst_wait_result", res_of(0), 0);
    @(negedge clk);
    chk(0, "rst_wait_still_idle", bz[0], 0);
    chk(0, "rst_wait_no_result", rv[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
